vga_fetch_scheduler: RTL and testbench
======================================

Name: vga_fetch_scheduler

Overview:
- Sequences frame-buffer burst reads that keep the VGA line FIFO full ahead of the scan-out path.
- The scan-out path only consumes RGB565 words from that FIFO inside the 1024x720 active picture window.
- Walks the active picture line by line, issues bounded read bursts with a req/ack/done handshake, and throttles on FIFO fill level.
- Sits between the frame-buffer read port arbiter and the display line FIFO.

Parameters:
- H_PIX, 1024, active pixels per line (16-bit words).
- V_LINES, 720, active lines per frame.
- LINE_STRIDE, 1024, word-address distance between consecutive lines in the frame buffer (LINE_STRIDE >= H_PIX).
- FRAME_BASE, 0, word address of pixel (0,0).
- BURST_LEN, 64, maximum words per read burst (>=1).
- FIFO_DEPTH, 512, line FIFO capacity in words (>= BURST_LEN).
- ADDR_W, 22, frame-buffer word-address width.
- LEVEL_W, 10, width of the FIFO level input (holds 0..FIFO_DEPTH).
- LEN_W, 7, burst length width (holds 0..BURST_LEN).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- Enable  in  1  fetching permitted.
- Frame_Start  in  1  one-cycle pulse at start of vertical blanking; begins a new frame fetch.
- Fifo_Level  in  LEVEL_W  current line-FIFO occupancy in words.
- Rd_Req  out  1  burst read request.
- Rd_Addr  out  ADDR_W  burst start word address; stable while Rd_Req=1.
- Rd_Len  out  LEN_W  burst length; stable while Rd_Req=1.
- Rd_Ack  in  1  arbiter accepted the request this cycle.
- Rd_Done  in  1  last word of the accepted burst has been written into the FIFO.
- Busy  out  1  a frame fetch is in progress.
- Frame_Done  out  1  one-cycle pulse after the final burst of a frame completes.
- Line_Cnt  out  11  index of the line currently being fetched.

Behaviour:
- Reset values (asynchronous on RST):
  - State IDLE.
  - Rd_Req=0, Rd_Addr=FRAME_BASE, Rd_Len=0.
  - Busy=0, Frame_Done=0, Line_Cnt=0.
  - Internal column counter=0, restart flag=0.
- All outputs are registered.
- FSM states: IDLE, WAIT_SPACE, REQ, WAIT_DONE, FRAME_END.
- IDLE:
  - Frame_Start=1 and Enable=1 -> WAIT_SPACE.
  - On entry: line base = FRAME_BASE, col=0, Line_Cnt=0, Busy=1.
  - Frame_Start is ignored while Enable=0.
- WAIT_SPACE:
  - Go to REQ when Fifo_Level + BURST_LEN <= FIFO_DEPTH. Compare at LEVEL_W+1 bits, no overflow.
  - Rd_Addr = line_base + col and Rd_Len = min(BURST_LEN, H_PIX - col) are registered on this transition.
  - Bursts never cross a line boundary.
- REQ:
  - Rd_Req=1 until the cycle Rd_Ack=1 is sampled; Rd_Req=0 the next cycle -> WAIT_DONE.
  - Rd_Addr and Rd_Len are held constant throughout.
- Rd_Ack and Rd_Done in the same cycle while in REQ: treated as accept plus immediate completion (go directly to the advance step).
- WAIT_DONE: on Rd_Done, advance in one cycle:
  - col += Rd_Len.
  - If col == H_PIX: col=0, line_base += LINE_STRIDE, Line_Cnt += 1.
  - If Line_Cnt reaches V_LINES -> FRAME_END, else -> WAIT_SPACE.
- FRAME_END: Frame_Done=1 for exactly one cycle, Busy=0 -> IDLE.
- Rd_Done and Rd_Ack are ignored in all states other than those listed above.
- Frame_Start while Busy:
  - In WAIT_SPACE or REQ before ack: Rd_Req drops next cycle; restart immediately from pixel (0,0). No Frame_Done.
  - In WAIT_DONE: set restart flag; on Rd_Done, restart from (0,0) instead of advancing. No Frame_Done.
- Enable deasserted while Busy:
  - An outstanding accepted burst completes (wait for Rd_Done); then go to IDLE with Busy=0 and no Frame_Done.
  - From WAIT_SPACE or un-acked REQ: go to IDLE next cycle.
- Address arithmetic is unsigned modulo 2^ADDR_W.
- Only one burst is outstanding at a time.

Test Plan:
- H_PIX=8, V_LINES=2, LINE_STRIDE=16, BURST_LEN=4, FRAME_BASE=0x100, Fifo_Level=0, Rd_Ack after 1 cycle, Rd_Done 3 cycles after ack -> requests exactly (0x100,4), (0x104,4), (0x110,4), (0x114,4); Frame_Done pulses once; Busy falls with it.
- H_PIX=10, BURST_LEN=4 -> per-line lengths 4,4,2; addresses base+0, +4, +8; no burst spans a line.
- FIFO_DEPTH=8, BURST_LEN=4, Fifo_Level held at 5 -> Rd_Req stays 0; drop Fifo_Level to 4 -> Rd_Req=1 within 2 cycles.
- Rd_Ack withheld 10 cycles -> Rd_Req, Rd_Addr and Rd_Len constant for all 10 cycles.
- Frame_Start pulse during WAIT_DONE of the third burst -> no new request until Rd_Done; next request at FRAME_BASE with Line_Cnt=0; no Frame_Done.
- RST asserted mid-REQ (async, between clock edges) -> Rd_Req=0 and Busy=0 immediately; Frame_Start with Enable=0 afterwards -> stays IDLE.

Source files
------------

// File: rtl/vga_fetch_scheduler.sv
// vga_fetch_scheduler
//   Walks the active picture line by line and issues frame-buffer read bursts
//   that keep the display line FIFO topped up ahead of scan-out. A burst is
//   requested only when the whole burst fits in the FIFO. Bursts never span a
//   line. Only one burst is in flight at a time.
//
// Ports
//   CLK, RST      clock, asynchronous active-high reset
//   Enable        fetching permitted; dropping it ends the frame fetch
//   Frame_Start   one-cycle pulse at vertical blanking; starts or restarts a frame
//   Fifo_Level    current line-FIFO occupancy in words
//   Rd_Req        burst request; Rd_Addr/Rd_Len are held stable while it is high
//   Rd_Addr       burst start word address
//   Rd_Len        burst length in words
//   Rd_Ack        arbiter accepted the request this cycle
//   Rd_Done       last word of the accepted burst has reached the FIFO
//   Busy          a frame fetch is in progress
//   Frame_Done    one-cycle pulse after the last burst of a frame completes
//   Line_Cnt      index of the line currently being fetched
module vga_fetch_scheduler #(
    parameter int H_PIX       = 1024,
    parameter int V_LINES     = 720,
    parameter int LINE_STRIDE = 1024,
    parameter int FRAME_BASE  = 0,
    parameter int BURST_LEN   = 64,
    parameter int FIFO_DEPTH  = 512,
    parameter int ADDR_W      = 22,
    parameter int LEVEL_W     = 10,
    parameter int LEN_W       = 7
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Enable,
    input  logic               Frame_Start,
    input  logic [LEVEL_W-1:0] Fifo_Level,
    output logic               Rd_Req,
    output logic [ADDR_W-1:0]  Rd_Addr,
    output logic [LEN_W-1:0]   Rd_Len,
    input  logic               Rd_Ack,
    input  logic               Rd_Done,
    output logic               Busy,
    output logic               Frame_Done,
    output logic [10:0]        Line_Cnt
);

    localparam int                 COL_W     = $clog2(H_PIX + 1);
    localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0]  STRIDE    = ADDR_W'(LINE_STRIDE);
    localparam logic [LEVEL_W:0]   LVL_BURST = (LEVEL_W + 1)'(BURST_LEN);
    localparam logic [LEVEL_W:0]   LVL_DEPTH = (LEVEL_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        WAIT_DONE,
        FRAME_END
    } state_t;

    state_t             state, state_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic [ADDR_W-1:0]  line_base, line_base_nxt;
    logic               restart, restart_nxt;
    logic               req_nxt, busy_nxt, frame_done_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [LEN_W-1:0]   len_nxt;
    logic [10:0]        line_cnt_nxt;

    logic               has_space;
    logic [31:0]        remaining;
    logic [LEN_W-1:0]   burst_len;
    logic [COL_W-1:0]   col_sum;
    logic               line_end, last_line;
    logic               finish, do_idle, do_restart;

    // Widened by one bit so level + burst cannot wrap.
    assign has_space = ({1'b0, Fifo_Level} + LVL_BURST) <= LVL_DEPTH;
    // Last burst of a line is clipped so it never spills into the next line.
    assign remaining = 32'(H_PIX) - 32'(col);
    assign burst_len = (remaining > 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remaining);
    assign col_sum   = col + COL_W'(Rd_Len);
    assign line_end  = (col_sum == COL_W'(H_PIX));
    assign last_line = ((Line_Cnt + 11'd1) == 11'(V_LINES));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        col_nxt        = col;
        line_base_nxt  = line_base;
        restart_nxt    = restart;
        req_nxt        = Rd_Req;
        addr_nxt       = Rd_Addr;
        len_nxt        = Rd_Len;
        busy_nxt       = Busy;
        frame_done_nxt = 1'b0;
        line_cnt_nxt   = Line_Cnt;
        finish         = 1'b0;
        do_idle        = 1'b0;
        do_restart     = 1'b0;

        unique case (state)
            IDLE: begin
                if (Frame_Start && Enable) do_restart = 1'b1;
            end
            WAIT_SPACE: begin
                if (!Enable) begin
                    do_idle = 1'b1;
                end else if (Frame_Start) begin
                    do_restart = 1'b1;
                end else if (has_space) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = line_base + ADDR_W'(col);
                    len_nxt   = burst_len;
                end
            end
            REQ: begin
                if (Rd_Ack) begin
                    // Once accepted the burst must be waited out, whatever
                    // Enable or Frame_Start do meanwhile.
                    req_nxt = 1'b0;
                    if (Rd_Done) begin
                        finish = 1'b1;
                    end else begin
                        state_nxt   = WAIT_DONE;
                        restart_nxt = Frame_Start;
                    end
                end else if (!Enable) begin
                    do_idle = 1'b1;
                end else if (Frame_Start) begin
                    do_restart = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (Rd_Done)          finish      = 1'b1;
                else if (Frame_Start) restart_nxt = 1'b1;
            end
            FRAME_END: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (finish) begin
            if (!Enable)                         do_idle    = 1'b1;
            else if (restart || Frame_Start)     do_restart = 1'b1;
            else if (line_end) begin
                col_nxt       = '0;
                line_base_nxt = line_base + STRIDE;
                line_cnt_nxt  = Line_Cnt + 11'd1;
                restart_nxt   = 1'b0;
                if (last_line) begin
                    state_nxt      = FRAME_END;
                    busy_nxt       = 1'b0;
                    frame_done_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT_SPACE;
                end
            end else begin
                col_nxt     = col_sum;
                restart_nxt = 1'b0;
                state_nxt   = WAIT_SPACE;
            end
        end

        if (do_idle) begin
            state_nxt   = IDLE;
            req_nxt     = 1'b0;
            busy_nxt    = 1'b0;
            restart_nxt = 1'b0;
        end

        if (do_restart) begin
            state_nxt     = WAIT_SPACE;
            req_nxt       = 1'b0;
            busy_nxt      = 1'b1;
            restart_nxt   = 1'b0;
            col_nxt       = '0;
            line_base_nxt = BASE;
            line_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col        <= '0;
            line_base  <= BASE;
            restart    <= 1'b0;
            Rd_Req     <= 1'b0;
            Rd_Addr    <= BASE;
            Rd_Len     <= '0;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
            Line_Cnt   <= '0;
        end else begin
            col        <= col_nxt;
            line_base  <= line_base_nxt;
            restart    <= restart_nxt;
            Rd_Req     <= req_nxt;
            Rd_Addr    <= addr_nxt;
            Rd_Len     <= len_nxt;
            Busy       <= busy_nxt;
            Frame_Done <= frame_done_nxt;
            Line_Cnt   <= line_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// tb_vga_fetch_scheduler
//   Small-frame instance (10x2 pixels, stride 16, base 0x100, 4-word bursts,
//   8-word FIFO). A table of bursts drives one deterministic frame, hand-written
//   sequences cover throttling, restarts, Enable drop and async reset, and
//   randomized frames are checked against a burst list derived from the
//   frame geometry.
module tb_vga_fetch_scheduler;

    localparam int H_PIX       = 10;
    localparam int V_LINES     = 2;
    localparam int LINE_STRIDE = 16;
    localparam int FRAME_BASE  = 'h100;
    localparam int BURST_LEN   = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int ADDR_W      = 12;
    localparam int LEVEL_W     = 4;
    localparam int LEN_W       = 3;
    localparam int N_RAND      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable, frame_start, rd_ack, rd_done;
    logic [LEVEL_W-1:0] fifo_level;
    logic              rd_req, busy, frame_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic [10:0]       line_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;

    typedef struct {
        int                ack_wait;
        int                done_wait;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [10:0]       line;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [10:0]       line;
    } burst_t;

    vec_t   tbl[6];
    burst_t exp_q[$];

    vga_fetch_scheduler #(
        .H_PIX(H_PIX), .V_LINES(V_LINES), .LINE_STRIDE(LINE_STRIDE),
        .FRAME_BASE(FRAME_BASE), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W(ADDR_W), .LEVEL_W(LEVEL_W), .LEN_W(LEN_W)
    ) dut (
        .CLK(clk), .RST(rst), .Enable(enable), .Frame_Start(frame_start),
        .Fifo_Level(fifo_level), .Rd_Req(rd_req), .Rd_Addr(rd_addr),
        .Rd_Len(rd_len), .Rd_Ack(rd_ack), .Rd_Done(rd_done), .Busy(busy),
        .Frame_Done(frame_done), .Line_Cnt(line_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
    endtask

    task automatic start_frame(input string tag);
        enable = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check({tag, " busy_on_start"}, 32'(busy), 32'd1);
    endtask

    // Waits for Rd_Req; the level that let it rise must have left room for a burst.
    task automatic wait_req(input string tag, input bit rand_lvl, output bit got);
        int n = 0;
        logic [LEVEL_W-1:0] lvl;
        got = rd_req;
        while (!got && n < 100) begin
            lvl = rand_lvl ? LEVEL_W'($urandom_range(0, FIFO_DEPTH)) : '0;
            fifo_level = lvl;
            step();
            n++;
            got = rd_req;
            if (got) check({tag, " space"}, 32'(int'(lvl) + BURST_LEN <= FIFO_DEPTH), 32'd1);
        end
        if (!got) check({tag, " req_timeout"}, 32'(rd_req), 32'd1);
    endtask

    task automatic hold_ack(input string tag, input int ack_wait, input bit done_now,
                            input logic [ADDR_W-1:0] e_addr, input logic [LEN_W-1:0] e_len);
        for (int i = 0; i < ack_wait; i++) begin
            step();
            check({tag, " req_held"}, 32'(rd_req), 32'd1);
            check({tag, " addr_held"}, 32'(rd_addr), 32'(e_addr));
            check({tag, " len_held"}, 32'(rd_len), 32'(e_len));
        end
        rd_ack = 1'b1;
        rd_done = done_now;
        step();
        rd_ack = 1'b0;
        rd_done = 1'b0;
        check({tag, " req_drop"}, 32'(rd_req), 32'd0);
    endtask

    task automatic finish_done(input string tag, input int done_wait);
        for (int i = 1; i < done_wait; i++) begin
            step();
            check({tag, " no_req_in_flight"}, 32'(rd_req), 32'd0);
            check({tag, " busy_in_flight"}, 32'(busy), 32'd1);
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    task automatic run_burst(input string tag, input int ack_wait, input int done_wait,
                             input bit rand_lvl, input logic [ADDR_W-1:0] e_addr,
                             input logic [LEN_W-1:0] e_len, input logic [10:0] e_line);
        bit got;
        wait_req(tag, rand_lvl, got);
        if (!got) return;
        check({tag, " addr"}, 32'(rd_addr), 32'(e_addr));
        check({tag, " len"}, 32'(rd_len), 32'(e_len));
        check({tag, " line"}, 32'(line_cnt), 32'(e_line));
        hold_ack(tag, ack_wait, done_wait == 0, e_addr, e_len);
        if (done_wait > 0) finish_done(tag, done_wait);
    endtask

    task automatic check_frame_end(input string tag);
        check({tag, " frame_done"}, 32'(frame_done), 32'd1);
        check({tag, " busy_fall"}, 32'(busy), 32'd0);
        check({tag, " line_final"}, 32'(line_cnt), 32'(V_LINES));
        step();
        check({tag, " frame_done_pulse"}, 32'(frame_done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    // Every burst of one frame, straight from the geometry.
    task automatic build_frame();
        burst_t b;
        int     len;
        exp_q.delete();
        for (int ln = 0; ln < V_LINES; ln++) begin
            for (int c = 0; c < H_PIX; c += BURST_LEN) begin
                len    = (H_PIX - c < BURST_LEN) ? H_PIX - c : BURST_LEN;
                b.addr = ADDR_W'(FRAME_BASE + ln * LINE_STRIDE + c);
                b.len  = LEN_W'(len);
                b.line = 11'(ln);
                exp_q.push_back(b);
            end
        end
    endtask

    initial begin
        bit     got;
        burst_t b;

        tbl[0] = '{1,  3, 12'h100, 3'd4, 11'd0};
        tbl[1] = '{10, 3, 12'h104, 3'd4, 11'd0};
        tbl[2] = '{0,  0, 12'h108, 3'd2, 11'd0};
        tbl[3] = '{1,  1, 12'h110, 3'd4, 11'd1};
        tbl[4] = '{2,  5, 12'h114, 3'd4, 11'd1};
        tbl[5] = '{1,  3, 12'h118, 3'd2, 11'd1};

        rst = 1'b1; enable = 1'b0; frame_start = 1'b0;
        rd_ack = 1'b0; rd_done = 1'b0; fifo_level = '0;
        #12;
        check("rst rd_req", 32'(rd_req), 32'd0);
        check("rst rd_addr", 32'(rd_addr), 32'h100);
        check("rst rd_len", 32'(rd_len), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst line_cnt", 32'(line_cnt), 32'd0);
        #1 rst = 1'b0;

        // Deterministic frame from the table.
        start_frame("tbl");
        for (int i = 0; i < 6; i++)
            run_burst($sformatf("tbl[%0d]", i), tbl[i].ack_wait, tbl[i].done_wait, 1'b0,
                      tbl[i].addr, tbl[i].len, tbl[i].line);
        check_frame_end("tbl");
        check("tbl frame_done_count", 32'(fd_cnt), 32'd1);

        // Throttle: level 5 leaves no room; stray ack/done must be ignored.
        fifo_level = 4'd5;
        start_frame("thr");
        rd_ack = 1'b1; rd_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("thr no_req", 32'(rd_req), 32'd0);
        end
        rd_ack = 1'b0; rd_done = 1'b0;
        check("thr busy", 32'(busy), 32'd1);
        fifo_level = 4'd4;
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            step();
            got = rd_req;
        end
        check("thr release", 32'(rd_req), 32'd1);
        check("thr addr", 32'(rd_addr), 32'h100);

        // Restart while an un-acked request is pending.
        fifo_level = '0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("rq_restart req_drop", 32'(rd_req), 32'd0);
        check("rq_restart busy", 32'(busy), 32'd1);
        step();
        check("rq_restart req", 32'(rd_req), 32'd1);
        check("rq_restart addr", 32'(rd_addr), 32'h100);

        // Restart while the third burst is in flight.
        run_burst("wd b0", 1, 2, 1'b0, 12'h100, 3'd4, 11'd0);
        run_burst("wd b1", 0, 1, 1'b0, 12'h104, 3'd4, 11'd0);
        wait_req("wd b2", 1'b0, got);
        check("wd b2 addr", 32'(rd_addr), 32'h108);
        hold_ack("wd b2", 0, 1'b0, 12'h108, 3'd2);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wd hold no_req", 32'(rd_req), 32'd0);
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("wd line_reset", 32'(line_cnt), 32'd0);
        wait_req("wd next", 1'b0, got);
        check("wd next addr", 32'(rd_addr), 32'h100);
        check("wd next line", 32'(line_cnt), 32'd0);
        check("wd no_frame_done", 32'(fd_cnt), 32'd1);

        // Enable dropped with a burst in flight: finish it, then go idle.
        hold_ack("en", 0, 1'b0, 12'h100, 3'd4);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en busy_until_done", 32'(busy), 32'd1);
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("en busy_off", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("en stays_idle", 32'(rd_req), 32'd0);
        end
        check("en no_frame_done", 32'(fd_cnt), 32'd1);

        // Enable dropped while waiting for space.
        fifo_level = 4'd8;
        start_frame("ws");
        enable = 1'b0;
        step();
        check("ws busy_off", 32'(busy), 32'd0);
        step();
        check("ws no_req", 32'(rd_req), 32'd0);

        // Randomized frames against the geometry-derived burst list.
        for (int f = 0; f < N_RAND; f++) begin
            build_frame();
            start_frame($sformatf("rnd%0d", f));
            while (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                run_burst($sformatf("rnd%0d", f), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 1'b1, b.addr, b.len, b.line);
            end
            check_frame_end($sformatf("rnd%0d", f));
        end
        check("rnd frame_done_count", 32'(fd_cnt), 32'(1 + N_RAND));

        // Asynchronous reset in the middle of a request.
        fifo_level = '0;
        start_frame("ar");
        wait_req("ar", 1'b0, got);
        #2 rst = 1'b1;
        #1;
        check("ar rd_req", 32'(rd_req), 32'd0);
        check("ar busy", 32'(busy), 32'd0);
        check("ar rd_addr", 32'(rd_addr), 32'h100);
        #2 rst = 1'b0;
        enable = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar ignored busy", 32'(busy), 32'd0);
            check("ar ignored req", 32'(rd_req), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
